// File: rtl/onewire_multi_master.sv
// onewire_multi_master: multi-channel 1-wire bus master with built-in slot timing
// Optional feature: define ONEWIRE_CRC8_EN to add o_crc_ok (Dallas CRC-8 over read bits).
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready command handshake; i_cmd_op/cnt/chan/data latched on accept
//   o_busy, o_done, o_err   command in progress, 1-cycle end pulse, sticky illegal-command flag
//   o_rd_data               read shift buffer, each new bit enters at [63]
//   o_presence              per-channel presence result of the last reset on that channel
//   o_wire_out, i_wire_in   open-drain drive (1 = release) and raw DQ level per channel
//   o_crc_ok                (ONEWIRE_CRC8_EN only) CRC-8 over all read bytes came out zero
module onewire_multi_master #(
    parameter int CHANNELS     = 4,
    parameter int TICKS_PER_US = 25,
    parameter int MAX_BYTES    = 8,
    localparam int CW          = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [3:0]          i_cmd_op,
    input  logic [3:0]          i_cmd_cnt,
    input  logic [CW-1:0]       i_cmd_chan,
    input  logic [63:0]         i_cmd_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [63:0]         o_rd_data,
    output logic [CHANNELS-1:0] o_presence,
    output logic [CHANNELS-1:0] o_wire_out,
`ifdef ONEWIRE_CRC8_EN
    output logic                o_crc_ok,
`endif
    input  logic [CHANNELS-1:0] i_wire_in
);
    localparam int T  = TICKS_PER_US;
    localparam int TW = $clog2(960 * T + 1);
    // Timer reload values are duration-1 because the zero count is itself a cycle.
    localparam logic [TW-1:0] T_RST  = TW'(480 * T - 1);
    localparam logic [TW-1:0] T_PRES = TW'(410 * T - 1);
    localparam logic [TW-1:0] T_L60  = TW'(60 * T - 1);
    localparam logic [TW-1:0] T_L6   = TW'(6 * T - 1);
    localparam logic [TW-1:0] T_R10  = TW'(10 * T - 1);
    localparam logic [TW-1:0] T_R64  = TW'(64 * T - 1);
    localparam logic [TW-1:0] T_SAMP = TW'(55 * T - 1);

    typedef enum logic [2:0] {IDLE, RST_LOW, RST_REL, SLOT_LOW, SLOT_REL, DONE} state_t;

    state_t              r_state;
    logic [TW-1:0]       r_timer;
    logic [CW-1:0]       r_chan;
    logic [63:0]         r_data, r_rd_data;
    logic [6:0]          r_bits;
    logic                r_wr, r_rd, r_busy, r_done, r_err;
    logic [CHANNELS-1:0] r_presence, r_wire_out, r_sync1, r_sync2;
    logic                w_illegal, w_dq;
    logic [TW-1:0]       w_low_acc, w_low_nxt;
    logic [CHANNELS-1:0] w_mask_acc, w_mask_r;

    assign w_illegal  = (i_cmd_op > 4'd3) || 32'(i_cmd_chan) >= CHANNELS ||
                        ((i_cmd_op == 4'd1 || i_cmd_op == 4'd2) && 32'(i_cmd_cnt) > MAX_BYTES);
    assign w_low_acc  = (i_cmd_op == 4'd1 && !i_cmd_data[0]) ? T_L60 : T_L6;
    // Next slot's bit is r_data[1] because r_data shifts at the end of the current slot.
    assign w_low_nxt  = (r_wr && !r_data[1]) ? T_L60 : T_L6;
    assign w_mask_acc = ~(CHANNELS'(1) << i_cmd_chan);
    assign w_mask_r   = ~(CHANNELS'(1) << r_chan);
    assign w_dq       = r_sync2[r_chan];

    assign o_cmd_ready = ~r_busy;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_rd_data   = r_rd_data;
    assign o_presence  = r_presence;
    assign o_wire_out  = r_wire_out;

`ifdef ONEWIRE_CRC8_EN
    logic       r_crc_ok, r_bytes;
    logic [7:0] r_crc, w_crc_nxt;
    // Reflected x^8+x^5+x^4+1, one bit per step.
    assign w_crc_nxt = {1'b0, r_crc[7:1]} ^ ((r_crc[0] ^ w_dq) ? 8'h8C : 8'h00);
    assign o_crc_ok  = r_crc_ok;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_chan     <= '0;
            r_data     <= '0;
            r_rd_data  <= '0;
            r_bits     <= '0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_presence <= '0;
            r_wire_out <= '1;
            r_sync1    <= '1;
            r_sync2    <= '1;
`ifdef ONEWIRE_CRC8_EN
            r_crc      <= '0;
            r_crc_ok   <= 1'b0;
            r_bytes    <= 1'b0;
`endif
        end else begin
            r_sync1 <= i_wire_in;
            r_sync2 <= r_sync1;
            case (r_state)
                IDLE: if (i_cmd_valid) begin
                    r_busy <= 1'b1;
                    r_err  <= w_illegal;
                    r_chan <= i_cmd_chan;
                    r_data <= i_cmd_data;
                    r_wr   <= i_cmd_op == 4'd1;
                    r_rd   <= i_cmd_op == 4'd2;
                    r_bits <= i_cmd_cnt == 4'd0 ? 7'd1 : {i_cmd_cnt, 3'b000};
`ifdef ONEWIRE_CRC8_EN
                    r_crc    <= '0;
                    r_crc_ok <= 1'b0;
                    r_bytes  <= i_cmd_cnt != 4'd0;
`endif
                    if (i_cmd_op == 4'd2) r_rd_data <= '0;
                    if (w_illegal || i_cmd_op == 4'd3) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= i_cmd_op == 4'd0 ? RST_LOW : SLOT_LOW;
                        r_timer    <= i_cmd_op == 4'd0 ? T_RST : w_low_acc;
                        r_wire_out <= w_mask_acc;
                    end
                end
                RST_LOW: if (r_timer == '0) begin
                    r_wire_out <= '1;
                    r_state    <= RST_REL;
                    r_timer    <= T_RST;
                end else r_timer <= r_timer - TW'(1);
                RST_REL: begin
                    if (r_timer == T_PRES) r_presence[r_chan] <= ~w_dq;
                    if (r_timer == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else r_timer <= r_timer - TW'(1);
                end
                SLOT_LOW: if (r_timer == '0) begin
                    r_wire_out <= '1;
                    r_state    <= SLOT_REL;
                    r_timer    <= (r_wr && !r_data[0]) ? T_R10 : T_R64;
                end else r_timer <= r_timer - TW'(1);
                SLOT_REL: begin
                    if (r_rd && r_timer == T_SAMP) begin
                        r_rd_data <= {w_dq, r_rd_data[63:1]};
`ifdef ONEWIRE_CRC8_EN
                        r_crc <= w_crc_nxt;
`endif
                    end
                    if (r_timer == '0) begin
                        r_data <= r_data >> 1;
                        r_bits <= r_bits - 7'd1;
                        if (r_bits == 7'd1) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
`ifdef ONEWIRE_CRC8_EN
                            r_crc_ok <= r_rd && r_bytes && r_crc == 8'h00;
`endif
                        end else begin
                            r_state    <= SLOT_LOW;
                            r_timer    <= w_low_nxt;
                            r_wire_out <= w_mask_r;
                        end
                    end else r_timer <= r_timer - TW'(1);
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_onewire_multi_master.sv
// tb_onewire_multi_master: directed self-checking bench for onewire_multi_master
module tb_onewire_multi_master;
    localparam int CH = 4;

    logic          clk = 1'b0, rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [3:0]    cmd_op = '0, cmd_cnt = '0;
    logic [1:0]    cmd_chan = '0;
    logic [63:0]   cmd_data = '0;
    logic          cmd_ready, busy, done, err;
    logic [63:0]   rd_data;
    logic [CH-1:0] presence, wire_out, wire_in;
    logic [CH-1:0] pull = '0, prev = '1;
`ifdef ONEWIRE_CRC8_EN
    logic          crc_ok;
`endif

    int checks = 0, errors = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, fall_cyc = 0, rise_cyc = 0;
    int mon_ch = 0, mode = 0, ridx = 0, pull_until = 0, d0 = 0, ftot = 0;
    int falls[CH] = '{default: 0};
    int lens[$], starts[$];
    logic          rise_seen = 1'b0;
    logic [127:0]  rbits = '0;
    int exp_len[8] = '{1500, 1500, 150, 150, 1500, 1500, 150, 150};

    always #20 clk = ~clk;
    // Open-drain bus: the line is low if either master or slave model pulls it.
    assign wire_in = wire_out & ~pull;

    onewire_multi_master dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_cnt(cmd_cnt), .i_cmd_chan(cmd_chan), .i_cmd_data(cmd_data),
        .o_busy(busy), .o_done(done), .o_err(err), .o_rd_data(rd_data),
        .o_presence(presence), .o_wire_out(wire_out),
`ifdef ONEWIRE_CRC8_EN
        .o_crc_ok(crc_ok),
`endif
        .i_wire_in(wire_in)
    );

    // Bus monitor and slave model: mode 1 answers a reset with presence,
    // mode 2 answers read slots from rbits (a 0 bit holds DQ low for 30 us).
    initial forever begin
        @(negedge clk);
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        for (int c = 0; c < CH; c++) begin
            if (prev[c] && !wire_out[c]) begin
                falls[c]++;
                if (c == mon_ch) begin
                    fall_cyc = cyc;
                    starts.push_back(cyc);
                    if (mode == 2) begin
                        if (!rbits[ridx]) pull_until = cyc + 750;
                        ridx++;
                    end
                end
            end
            if (!prev[c] && wire_out[c] && c == mon_ch) begin
                lens.push_back(cyc - fall_cyc);
                rise_cyc  = cyc;
                rise_seen = 1'b1;
            end
        end
        prev = wire_out;
        pull = '0;
        if (mode == 1 && rise_seen && cyc - rise_cyc >= 375 && cyc - rise_cyc < 6000) pull[mon_ch] = 1'b1;
        if (mode == 2 && cyc < pull_until) pull[mon_ch] = 1'b1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] cnt, input logic [1:0] ch, input logic [63:0] d);
        tick();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_chan  = ch;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " done reached"}, 64'(n < budget), 64'(1));
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset wire_out", 64'(wire_out), 64'hF);
        chk("reset busy", 64'(busy), 0);
        chk("reset ready", 64'(cmd_ready), 1);
        chk("reset done", 64'(done), 0);
        chk("reset err", 64'(err), 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset presence", 64'(presence), 0);

        // Reset/presence on channel 2
        mon_ch = 2; mode = 1; rise_seen = 1'b0; lens.delete();
        send(4'd0, 4'd0, 2'd2, 64'd0);
        chk("rst busy after accept", 64'(busy), 1);
        wait_done(30000, "rst");
        chk("rst pulse count", 64'(lens.size()), 1);
        chk("rst low length", 64'(lens[0]), 12000);
        chk("rst done time", 64'(done_cyc - fall_cyc), 24000);
        chk("rst presence", 64'(presence), 64'b0100);
        chk("rst other channels", 64'(falls[0] + falls[1] + falls[3]), 0);
        tick();
        chk("rst done pulse width", 64'(done), 0);
        chk("rst busy cleared", 64'(busy), 0);
        mode = 0;

        // Write one byte 0xCC on channel 0; a command issued while busy is ignored
        mon_ch = 0; lens.delete(); starts.delete();
        for (int c = 0; c < CH; c++) falls[c] = 0;
        d0 = done_cnt;
        send(4'd1, 4'd1, 2'd0, 64'hCC);
        repeat (10) tick();
        cmd_valid = 1'b1; cmd_op = 4'd7; cmd_chan = 2'd3;
        tick();
        cmd_valid = 1'b0;
        chk("busy cmd ignored err", 64'(err), 0);
        chk("busy cmd ignored busy", 64'(busy), 1);
        wait_done(20000, "write");
        tick();
        chk("write slot count", 64'(falls[0]), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("write low len bit%0d", i), 64'(lens[i]), 64'(exp_len[i]));
        for (int i = 1; i < 8; i++) chk($sformatf("write slot period %0d", i), 64'(starts[i] - starts[i-1]), 1750);
        chk("write done once", 64'(done_cnt - d0), 1);
        chk("write others untouched", 64'(falls[1] + falls[2] + falls[3]), 0);
        chk("write err", 64'(err), 0);

        // Read two bytes 0x28, 0xFF on channel 1
        mon_ch = 1; mode = 2; ridx = 0; rbits = {112'd0, 16'hFF28};
        send(4'd2, 4'd2, 2'd1, 64'd0);
        wait_done(40000, "read");
`ifdef ONEWIRE_CRC8_EN
        chk("read crc_ok bad", 64'(crc_ok), 0);
`endif
        tick();
        chk("read rd_data hi", 64'(rd_data[63:48]), 64'hFF28);
        chk("read rd_data lo", 64'(rd_data[47:0]), 0);
        chk("read busy after", 64'(busy), 0);
        chk("read slot count", 64'(ridx), 16);
        mode = 0;

        // Illegal and status commands
        ftot = falls[0] + falls[1] + falls[2] + falls[3];
        send(4'd1, 4'd9, 2'd0, '1);
        chk("cnt9 done", 64'(done), 1);
        chk("cnt9 err", 64'(err), 1);
        tick();
        chk("cnt9 done pulse width", 64'(done), 0);
        chk("cnt9 err sticky", 64'(err), 1);
        send(4'd7, 4'd0, 2'd0, 64'd0);
        chk("op7 done", 64'(done), 1);
        chk("op7 err", 64'(err), 1);
        send(4'd2, 4'd9, 2'd3, 64'd0);
        chk("read cnt9 err", 64'(err), 1);
        send(4'd3, 4'd0, 2'd0, 64'd0);
        chk("op3 done", 64'(done), 1);
        chk("op3 clears err", 64'(err), 0);
        tick();
        chk("illegal no bus edges", 64'(falls[0] + falls[1] + falls[2] + falls[3]), 64'(ftot));

        // Asynchronous reset in the middle of RST_LOW on channel 1
        mon_ch = 1;
        send(4'd0, 4'd0, 2'd1, 64'd0);
        repeat (100) tick();
        chk("mid reset low", 64'(wire_out), 64'b1101);
        #5 rst = 1'b1;
        #1;
        chk("async rst wire_out", 64'(wire_out), 64'hF);
        chk("async rst busy", 64'(busy), 0);
        chk("async rst presence", 64'(presence), 0);
        tick();
        rst = 1'b0;
        tick();

`ifdef ONEWIRE_CRC8_EN
        // A zero byte has CRC zero; a single-bit read never reports crc_ok
        mon_ch = 1; mode = 2; ridx = 0; rbits = '0;
        send(4'd2, 4'd1, 2'd1, 64'd0);
        wait_done(20000, "crc byte");
        chk("crc_ok good byte", 64'(crc_ok), 1);
        send(4'd2, 4'd0, 2'd1, 64'd0);
        chk("crc_ok cleared on accept", 64'(crc_ok), 0);
        wait_done(5000, "crc bit");
        chk("crc_ok bit read", 64'(crc_ok), 0);
        mode = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
